// File: rtl/mcu_local_axil_wr_fsm.sv
// rtl/mcu_local_axil_wr_fsm.sv - AXI-Stream result beats written back to memory over AXI-Lite
//
// Purpose:
//   Accepts result beats on s_axis_* and writes each one to memory over an
//   AXI-Lite write channel. The byte address comes from a word counter that
//   runs from 0 to addr_counter_max-1. That sweep repeats inter_counter_max
//   times. Completion (done) and failure (error) are reported to the global FSM.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last}
//                              input result stream
//   m_axil_aw{addr,prot,valid,ready}
//                              AXI-Lite write address channel
//   m_axil_w{data,strb,valid,ready}
//                              AXI-Lite write data channel
//   m_axil_b{resp,valid,ready} AXI-Lite write response channel
//   glo_fsm_state              global FSM state (START / ERROR / END encodings)
//   addr_counter_max           words per iteration (ADDR_WIDTH+1 bits, 2^ADDR_WIDTH legal)
//   inter_counter_max          number of iterations
//   done                       every write issued and acknowledged
//   error                      block is in its error state
//
// Optional feature:
//   MCU_WR_TLAST_CHECK_EN - when defined, s_axis_tlast must be high exactly on
//   the final beat. A mismatched beat is dropped and the block enters ERR.

module mcu_local_axil_wr_fsm #(
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH       = 32,
  parameter int INTER_ITER_WIDTH = 32,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int GLO_FSM_WIDTH    = 2,
  parameter int GLO_FSM_STR      = 0,
  parameter int GLO_FSM_ERR      = 2,
  parameter int GLO_FSM_END      = 3
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,

  output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
  output logic [2:0]                  m_axil_awprot,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,

  output logic [DATA_WIDTH-1:0]       m_axil_wdata,
  output logic [DATA_STRB_WIDTH-1:0]  m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,

  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,

  input  logic [GLO_FSM_WIDTH-1:0]    glo_fsm_state,
  input  logic [ADDR_WIDTH:0]         addr_counter_max,
  input  logic [INTER_ITER_WIDTH-1:0] inter_counter_max,

  output logic                        done,
  output logic                        error
);

  localparam int STRB_SHIFT = $clog2(DATA_STRB_WIDTH);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OUT_W-1:0]            OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]            OUT_ONE  = OUT_W'(1);
  localparam logic [ADDR_WIDTH:0]         WORD_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [INTER_ITER_WIDTH-1:0] ITER_ONE = INTER_ITER_WIDTH'(1);

  localparam logic [GLO_FSM_WIDTH-1:0] GLO_STR = GLO_FSM_WIDTH'(GLO_FSM_STR);
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_ERR = GLO_FSM_WIDTH'(GLO_FSM_ERR);
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_END = GLO_FSM_WIDTH'(GLO_FSM_END);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                      state;
  logic [ADDR_WIDTH:0]         word_cnt;
  logic [INTER_ITER_WIDTH-1:0] iter_cnt;
  logic [OUT_W-1:0]            outstanding;

  // The pending flags are the AW/W valids themselves; each clears on its own handshake.
  logic aw_pend;
  logic w_pend;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic out_ok;
  logic run_ready;
  logic accept;
  logic word_last;
  logic iter_last;
  logic final_beat;
  logic tlast_bad;
  logic b_err;
  logic go_err;
  logic launch;
  logic cfg_zero;
  logic drained;
  logic [ADDR_WIDTH:0] byte_addr;

  assign m_axil_awvalid = aw_pend;
  assign m_axil_wvalid  = w_pend;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_wstrb   = '1;

  assign aw_hs = aw_pend && m_axil_awready;
  assign w_hs  = w_pend && m_axil_wready;
  assign b_hs  = m_axil_bvalid && m_axil_bready;

  // A B response that arrives in the same cycle frees a slot, so the block
  // keeps streaming at full rate while the window is full.
  assign out_ok    = (outstanding < OUT_MAX) || b_hs;
  assign run_ready = (!aw_pend || m_axil_awready) &&
                     (!w_pend  || m_axil_wready)  &&
                     out_ok;

  // In ERR the stream is sunk so the upstream stage can drain and not deadlock.
  assign s_axis_tready = ((state == S_RUN) && run_ready) || (state == S_ERR);
  assign m_axil_bready = (state == S_RUN) || (state == S_DRAIN) || (state == S_ERR);

  assign accept     = (state == S_RUN) && s_axis_tvalid && s_axis_tready;
  assign word_last  = (word_cnt == (addr_counter_max - WORD_ONE));
  assign iter_last  = (iter_cnt == (inter_counter_max - ITER_ONE));
  assign final_beat = word_last && iter_last;
  assign cfg_zero   = (addr_counter_max == '0) || (inter_counter_max == '0);
  assign drained    = !aw_pend && !w_pend && (outstanding == '0);

  // The shift is done at ADDR_WIDTH+1 bits and then truncated. This lets
  // word_cnt reach 2^ADDR_WIDTH-1 without a wider intermediate.
  assign byte_addr = word_cnt << STRB_SHIFT;

`ifdef MCU_WR_TLAST_CHECK_EN
  assign tlast_bad = accept && (s_axis_tlast != final_beat);
`else
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
  assign tlast_bad    = 1'b0;
`endif

  // A B handshake with outstanding==0 has no matching write, so it is treated as an error.
  assign b_err  = b_hs && ((m_axil_bresp != 2'b00) || (outstanding == '0));
  assign go_err = (((state == S_RUN) || (state == S_DRAIN)) && b_err) || tlast_bad;

  // If the block goes to ERR in the same cycle that a beat is accepted, that beat is not launched.
  assign launch = accept && !go_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      word_cnt      <= '0;
      iter_cnt      <= '0;
      outstanding   <= '0;
      aw_pend       <= 1'b0;
      w_pend        <= 1'b0;
      m_axil_awaddr <= '0;
      m_axil_wdata  <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done  <= (state == S_DONE);
      error <= (state == S_ERR);

      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;

      if (launch) begin
        aw_pend       <= 1'b1;
        w_pend        <= 1'b1;
        m_axil_awaddr <= byte_addr[ADDR_WIDTH-1:0];
        m_axil_wdata  <= s_axis_tdata;
        if (word_last) begin
          word_cnt <= '0;
          iter_cnt <= iter_cnt + ITER_ONE;
        end else begin
          word_cnt <= word_cnt + WORD_ONE;
        end
      end

      // A launch and a B handshake in the same cycle cancel each other out.
      if (launch && !b_hs) begin
        outstanding <= outstanding + OUT_ONE;
      end else if (!launch && b_hs && (outstanding != '0)) begin
        outstanding <= outstanding - OUT_ONE;
      end

      case (state)
        S_IDLE: begin
          word_cnt    <= '0;
          iter_cnt    <= '0;
          outstanding <= '0;
          if (glo_fsm_state == GLO_STR) begin
            state <= cfg_zero ? S_ERR : S_RUN;
          end
        end

        S_RUN: begin
          if (go_err) begin
            state <= S_ERR;
          end else if (launch && final_beat) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (go_err) begin
            state <= S_ERR;
          end else if (drained) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          if (glo_fsm_state == GLO_END) begin
            state <= S_IDLE;
          end
        end

        S_ERR: begin
          if (glo_fsm_state == GLO_ERR) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_local_axil_wr_fsm.sv
// tb/tb_mcu_local_axil_wr_fsm.sv - directed self-checking bench for mcu_local_axil_wr_fsm

module tb_mcu_local_axil_wr_fsm;

  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int IW   = 32;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid;
  logic          m_axil_awready = 1'b1;
  logic [DW-1:0] m_axil_wdata;
  logic [1:0]    m_axil_wstrb;
  logic          m_axil_wvalid;
  logic          m_axil_wready = 1'b1;
  logic [1:0]    m_axil_bresp = 2'b00;
  logic          m_axil_bvalid = 1'b0;
  logic          m_axil_bready;
  logic [1:0]    glo_fsm_state = 2'd1;
  logic [AW:0]   addr_counter_max = '0;
  logic [IW-1:0] inter_counter_max = '0;
  logic          done;
  logic          error;

  mcu_local_axil_wr_fsm #(
    .DATA_WIDTH(DW), .DATA_STRB_WIDTH(DW/8), .ADDR_WIDTH(AW), .INTER_ITER_WIDTH(IW),
    .MAX_OUTSTANDING(MAXO), .GLO_FSM_WIDTH(2), .GLO_FSM_STR(0), .GLO_FSM_ERR(2), .GLO_FSM_END(3)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .glo_fsm_state(glo_fsm_state), .addr_counter_max(addr_counter_max),
    .inter_counter_max(inter_counter_max), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // stream source queue and slave configuration
  logic [DW-1:0] sq_data[$];
  logic          sq_last[$];
  int b_delay = 0;
  int slverr_at = 0;
  int aw_stall = 0;

  // handshake flags for the upcoming edge, captured on the falling edge
  logic aw_f = 1'b0, w_f = 1'b0, b_f = 1'b0, s_f = 1'b0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  int s_count = 0, b_count = 0, s_first_cyc = 0, s_last_cyc = 0, last_b_cyc = 0, max_unacked = 0;
  logic saw_full_stall = 1'b0, saw_w_only = 1'b0;

  int aw_n = 0, w_n = 0, paired = 0, b_idx = 0;
  int b_due[$];

  always @(negedge clk) begin
    if (rst) begin
      aw_f = 0; w_f = 0; b_f = 0; s_f = 0;
      aw_log.delete(); w_log.delete();
      s_count = 0; b_count = 0; s_first_cyc = 0; s_last_cyc = 0; last_b_cyc = 0; max_unacked = 0;
      saw_full_stall = 0; saw_w_only = 0;
    end else begin
      aw_f = m_axil_awvalid && m_axil_awready;
      w_f  = m_axil_wvalid && m_axil_wready;
      b_f  = m_axil_bvalid && m_axil_bready;
      s_f  = s_axis_tvalid && s_axis_tready;
      if (s_axis_tvalid && !s_axis_tready && (s_count - b_count) == MAXO) saw_full_stall = 1;
      if (w_f && !aw_f) saw_w_only = 1;
      if (aw_f) aw_log.push_back(m_axil_awaddr);
      if (w_f) w_log.push_back(m_axil_wdata);
      if (s_f) begin
        if (s_count == 0) s_first_cyc = cyc;
        s_last_cyc = cyc;
        s_count++;
      end
      if (b_f) begin
        b_count++;
        last_b_cyc = cyc;
      end
      if ((s_count - b_count) > max_unacked) max_unacked = s_count - b_count;
    end
  end

  // stream source and AXI-Lite slave, updated just after each rising edge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sq_data.delete(); sq_last.delete(); b_due.delete();
      s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
      m_axil_awready = 1; m_axil_wready = 1; m_axil_bvalid = 0; m_axil_bresp = 2'b00;
      aw_n = 0; w_n = 0; paired = 0; b_idx = 0; aw_stall = 0;
    end else begin
      if (s_f && sq_data.size() > 0) begin
        void'(sq_data.pop_front());
        void'(sq_last.pop_front());
      end
      s_axis_tvalid = (sq_data.size() > 0);
      s_axis_tdata  = (sq_data.size() > 0) ? sq_data[0] : '0;
      s_axis_tlast  = (sq_last.size() > 0) ? sq_last[0] : 1'b0;
      if (aw_f) aw_n++;
      if (w_f) w_n++;
      while (paired < aw_n && paired < w_n) begin
        b_due.push_back(cyc + b_delay);
        paired++;
      end
      m_axil_awready = (aw_stall == 0);
      if (m_axil_awvalid && aw_stall > 0) aw_stall--;
      if (m_axil_bvalid && b_f) begin
        m_axil_bvalid = 0;
        b_idx++;
      end
      if (!m_axil_bvalid && b_due.size() > 0 && cyc >= b_due[0]) begin
        void'(b_due.pop_front());
        m_axil_bvalid = 1;
        m_axil_bresp  = (b_idx + 1 == slverr_at) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1; glo_fsm_state = 2'd1; slverr_at = 0; b_delay = 0;
    step(2);
    rst = 0;
    step(1);
  endtask

  task automatic test_reset;
    rst = 1;
    step(2);
    vectors++; if (m_axil_awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid: got %b want 0", m_axil_awvalid); end
    vectors++; if (m_axil_wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid: got %b want 0", m_axil_wvalid); end
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    vectors++; if (m_axil_bready !== 1'b0) begin miscompares++; $display("FAIL reset_bready: got %b want 0", m_axil_bready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
    vectors++; if (m_axil_awaddr !== '0) begin miscompares++; $display("FAIL reset_awaddr: got %h want 0", m_axil_awaddr); end
    vectors++; if (m_axil_wdata !== '0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", m_axil_wdata); end
    rst = 0;
    step(1);
  endtask

  task automatic test_basic;
    int n;
    int done_cyc;
    do_reset();
    addr_counter_max = 4; inter_counter_max = 2;
    for (int i = 0; i < 8; i++) begin
      sq_data.push_back(16'hA000 + 16'(i));
      sq_last.push_back(i == 7);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin step(1); n++; end
    done_cyc = cyc;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done_timeout: got %b want 1", done); end
    vectors++; if (aw_log.size() != 8) begin miscompares++; $display("FAIL basic_aw_count: got %0d want 8", aw_log.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = AW'((i % 4) * 2);
      ed = 16'hA000 + 16'(i);
      vectors++;
      if (i >= aw_log.size() || aw_log[i] !== ea) begin
        miscompares++; $display("FAIL basic_awaddr[%0d]: got %h want %h", i, (i < aw_log.size()) ? aw_log[i] : '1, ea);
      end
      vectors++;
      if (i >= w_log.size() || w_log[i] !== ed) begin
        miscompares++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, (i < w_log.size()) ? w_log[i] : '1, ed);
      end
    end
    vectors++; if (done_cyc - last_b_cyc != 3) begin miscompares++; $display("FAIL basic_done_latency: got %0d want 3", done_cyc - last_b_cyc); end
    vectors++; if (s_last_cyc - s_first_cyc != 7) begin miscompares++; $display("FAIL basic_throughput: got %0d want 7", s_last_cyc - s_first_cyc); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b want 0", error); end
    vectors++; if (m_axil_awprot !== 3'b000 || m_axil_wstrb !== 2'b11) begin miscompares++; $display("FAIL basic_prot_strb: got %b/%b want 000/11", m_axil_awprot, m_axil_wstrb); end
    glo_fsm_state = 2'd3;
    step(2);
    glo_fsm_state = 2'd1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_end_done: got %b want 0", done); end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset();
    b_delay = 5; aw_stall = 3;
    addr_counter_max = 8; inter_counter_max = 1;
    for (int i = 0; i < 8; i++) begin
      sq_data.push_back(16'h5000 + 16'(i * 3));
      sq_last.push_back(i == 7);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (done !== 1'b1 && n < 300) begin step(1); n++; end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done_timeout: got %b want 1", done); end
    vectors++; if (max_unacked != MAXO) begin miscompares++; $display("FAIL bp_max_unacked: got %0d want %0d", max_unacked, MAXO); end
    vectors++; if (saw_full_stall !== 1'b1) begin miscompares++; $display("FAIL bp_tready_low_at_full: got %b want 1", saw_full_stall); end
    vectors++; if (saw_w_only !== 1'b1) begin miscompares++; $display("FAIL bp_w_independent: got %b want 1", saw_w_only); end
    vectors++; if (aw_log.size() != 8 || w_log.size() != 8) begin miscompares++; $display("FAIL bp_counts: got %0d/%0d want 8/8", aw_log.size(), w_log.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= aw_log.size() || i >= w_log.size() || aw_log[i] !== AW'(i * 2) || w_log[i] !== 16'h5000 + 16'(i * 3)) begin
        miscompares++; $display("FAIL bp_write[%0d]: got %h/%h want %h/%h", i,
          (i < aw_log.size()) ? aw_log[i] : '1, (i < w_log.size()) ? w_log[i] : '1, AW'(i * 2), 16'h5000 + 16'(i * 3));
      end
    end
  endtask

  task automatic test_error_resp;
    int n;
    int aw_at_err;
    do_reset();
    b_delay = 2; slverr_at = 3;
    addr_counter_max = 8; inter_counter_max = 1;
    for (int i = 0; i < 8; i++) begin
      sq_data.push_back(16'hE000 + 16'(i));
      sq_last.push_back(i == 7);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (error !== 1'b1 && n < 100) begin step(1); n++; end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_timeout: got %b want 1", error); end
    vectors++; if (s_axis_tready !== 1'b1 || m_axil_bready !== 1'b1) begin miscompares++; $display("FAIL err_ready: got %b/%b want 1/1", s_axis_tready, m_axil_bready); end
    aw_at_err = aw_log.size();
    step(20);
    vectors++; if (aw_log.size() != aw_at_err) begin miscompares++; $display("FAIL err_no_new_aw: got %0d want %0d", aw_log.size(), aw_at_err); end
    vectors++; if (aw_log.size() != 6) begin miscompares++; $display("FAIL err_aw_total: got %0d want 6", aw_log.size()); end
    vectors++; if (s_count != 8) begin miscompares++; $display("FAIL err_stream_sunk: got %0d want 8", s_count); end
    vectors++; if (m_axil_awvalid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL err_idle_outputs: got %b/%b want 0/0", m_axil_awvalid, done); end
    glo_fsm_state = 2'd2;
    step(2);
    glo_fsm_state = 2'd1;
    vectors++; if (error !== 1'b0 || s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL err_return_idle: got %b/%b want 0/0", error, s_axis_tready); end
  endtask

  task automatic test_zero_cfg;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      addr_counter_max  = (k == 0) ? 33'd0 : 33'd4;
      inter_counter_max = (k == 0) ? 32'd3 : 32'd0;
      glo_fsm_state = 2'd0;
      step(1);
      glo_fsm_state = 2'd1;
      vectors++; if (s_axis_tready !== 1'b1 || m_axil_bready !== 1'b1) begin miscompares++; $display("FAIL zero_err_state[%0d]: got %b/%b want 1/1", k, s_axis_tready, m_axil_bready); end
      step(1);
      vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL zero_error[%0d]: got %b want 1", k, error); end
      step(3);
      vectors++; if (aw_log.size() != 0 || w_log.size() != 0 || m_axil_awvalid !== 1'b0) begin miscompares++; $display("FAIL zero_no_axi[%0d]: got %0d/%0d want 0/0", k, aw_log.size(), w_log.size()); end
      glo_fsm_state = 2'd2;
      step(2);
      glo_fsm_state = 2'd1;
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL zero_recover[%0d]: got %b want 0", k, error); end
    end
  endtask

`ifdef MCU_WR_TLAST_CHECK_EN
  task automatic test_tlast_check;
    int n;
    do_reset();
    addr_counter_max = 4; inter_counter_max = 2;
    for (int i = 0; i < 8; i++) begin
      sq_data.push_back(16'hC000 + 16'(i));
      sq_last.push_back(i == 1);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (error !== 1'b1 && n < 50) begin step(1); n++; end
    step(3);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL tlast_error: got %b want 1", error); end
    vectors++; if (aw_log.size() != 1 || w_log.size() != 1) begin miscompares++; $display("FAIL tlast_writes: got %0d/%0d want 1/1", aw_log.size(), w_log.size()); end
  endtask
`endif

  task automatic test_midrun_reset;
    int n;
    do_reset();
    aw_stall = 50;
    addr_counter_max = 4; inter_counter_max = 1;
    for (int i = 0; i < 4; i++) begin
      sq_data.push_back(16'h3300 + 16'(i));
      sq_last.push_back(i == 3);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (m_axil_awvalid !== 1'b1 && n < 20) begin step(1); n++; end
    vectors++; if (m_axil_awvalid !== 1'b1) begin miscompares++; $display("FAIL mrst_awvalid_seen: got %b want 1", m_axil_awvalid); end
    rst = 1;
    step(1);
    vectors++; if (m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b0) begin miscompares++; $display("FAIL mrst_valids: got %b/%b want 0/0", m_axil_awvalid, m_axil_wvalid); end
    vectors++; if (s_axis_tready !== 1'b0 || m_axil_bready !== 1'b0) begin miscompares++; $display("FAIL mrst_idle: got %b/%b want 0/0", s_axis_tready, m_axil_bready); end
    step(1);
    rst = 0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      sq_data.push_back(16'h7700 + 16'(i));
      sq_last.push_back(i == 3);
    end
    glo_fsm_state = 2'd0;
    step(1);
    glo_fsm_state = 2'd1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin step(1); n++; end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mrst_rerun_done: got %b want 1", done); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= aw_log.size() || i >= w_log.size() || aw_log[i] !== AW'(i * 2) || w_log[i] !== 16'h7700 + 16'(i)) begin
        miscompares++; $display("FAIL mrst_rerun_write[%0d]: got %h/%h want %h/%h", i,
          (i < aw_log.size()) ? aw_log[i] : '1, (i < w_log.size()) ? w_log[i] : '1, AW'(i * 2), 16'h7700 + 16'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error_resp();
    test_zero_cfg();
`ifdef MCU_WR_TLAST_CHECK_EN
    test_tlast_check();
`endif
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
